// File: rtl/stepper_pulse_gen.sv
// Purpose : turns each tick's signed delta_steps into evenly spaced STEP pulses plus a DIR level.
// Latency : rise -> SAMPLE 1 clk; DIR_SETUP clks of setup; a crossing in RUN cycle j raises STEP at j+1.
// Backpressure: none; oversized requests are clamped and early ticks abort the window (sticky overrun).
module stepper_pulse_gen #(
  parameter int simPeriod          = 500_000,
  parameter int fixedPointBaseBits = 16,
  parameter int PULSE_WIDTH        = 100,
  parameter int DIR_SETUP          = 50
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 sync_sim_clock,
  input  logic signed [fixedPointBaseBits-1:0] delta_steps,
  input  logic                                 enable,
  input  logic                                 clear_pos,
  output logic                                 step,
  output logic                                 dir,
  output logic                                 busy,
  output logic                                 overrun,
  output logic signed [fixedPointBaseBits-1:0] pos_count
);

  localparam int W          = fixedPointBaseBits;
  localparam int RUN_CYCLES = simPeriod - DIR_SETUP;
  localparam int MAX_STEPS  = RUN_CYCLES / (2 * PULSE_WIDTH);
  localparam int RT_W       = $clog2(RUN_CYCLES + 1);
  localparam int ST_W       = $clog2(DIR_SETUP + 1);
  localparam int PW_W       = $clog2(PULSE_WIDTH + 1);

  localparam logic [31:0] RUN_C = 32'(RUN_CYCLES);
  localparam logic [31:0] MAX_C = 32'(MAX_STEPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    SETUP  = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            sim_prev;
  logic            rise;
  logic            abort;
  logic            sample_go;
  logic            load_run;
  logic            fire;
  logic            crossing;

  logic            delta_zero;
  logic            dir_new;
  logic [W-1:0]    mag_w;
  logic [31:0]     mag;
  logic            clamp;
  logic [31:0]     n_sel;

  logic [31:0]     n;
  logic [31:0]     acc;
  logic [31:0]     acc_sum;
  logic [ST_W-1:0] setup_tmr;
  logic [RT_W-1:0] run_tmr;
  logic [PW_W-1:0] pulse_tmr;

  // Tick edge detection in the clock domain.
  assign rise = sync_sim_clock & ~sim_prev;

  // Request magnitude: two's-complement negate keeps -2^(W-1) as 2^(W-1) unsigned, which then clamps.
  assign delta_zero = (delta_steps == '0);
  assign dir_new    = ~delta_steps[W-1];
  assign mag_w      = delta_steps[W-1] ? (~delta_steps + 1'b1) : delta_steps;
  assign mag        = 32'(mag_w);
  assign clamp      = (mag > MAX_C);
  assign n_sel      = clamp ? MAX_C : mag;

  // Bresenham-style accumulator: one pulse each time the running sum crosses the window length.
  assign acc_sum  = acc + n;
  assign crossing = (acc_sum >= RUN_C);

  // A rise while a window is in progress means the tick came early.
  assign abort = rise & enable & (state != IDLE);

  // SAMPLE holds while an in-flight pulse finishes so DIR never changes under a high STEP.
  assign sample_go = (state == SAMPLE) & enable & ~rise & ~step;
  assign load_run  = (state == SETUP) & (state_nxt == RUN);
  assign fire      = (state == RUN) & enable & ~rise & crossing;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: disable beats everything, then an enabled rise always restarts at SAMPLE.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (rise) begin
      state_nxt = SAMPLE;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SAMPLE:  if (!step) state_nxt = delta_zero ? IDLE : SETUP;
        SETUP:   if (setup_tmr <= ST_W'(1)) state_nxt = RUN;
        RUN:     if (run_tmr <= RT_W'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state == SETUP) || (state == RUN);
  end

  // Previous tick level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sim_prev <= 1'b0;
    end else begin
      sim_prev <= sync_sim_clock;
    end
  end

  // Latch the clamped step count and direction when the sample is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n   <= '0;
      dir <= 1'b0;
    end else if (sample_go) begin
      n <= n_sel;
      if (!delta_zero) begin
        dir <= dir_new;
      end
    end
  end

  // DIR setup timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      setup_tmr <= '0;
    end else if (sample_go && !delta_zero) begin
      setup_tmr <= ST_W'(DIR_SETUP);
    end else if ((state == SETUP) && (setup_tmr != '0)) begin
      setup_tmr <= setup_tmr - 1'b1;
    end
  end

  // Run window timer and accumulator; the half-window start offset centres pulses in the window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_tmr <= '0;
      acc     <= '0;
    end else if (load_run) begin
      run_tmr <= RT_W'(RUN_CYCLES);
      acc     <= RUN_C >> 1;
    end else if (state == RUN) begin
      if (run_tmr != '0) begin
        run_tmr <= run_tmr - 1'b1;
      end
      acc <= crossing ? (acc_sum - RUN_C) : acc_sum;
    end
  end

  // STEP pulse generator, independent of the FSM so a started pulse always completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step      <= 1'b0;
      pulse_tmr <= '0;
    end else if (fire) begin
      step      <= 1'b1;
      pulse_tmr <= PW_W'(PULSE_WIDTH - 1);
    end else if (pulse_tmr != '0) begin
      pulse_tmr <= pulse_tmr - 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

  // Sticky overrun: clamped request or aborted window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if ((sample_go && !delta_zero && clamp) || abort) begin
      overrun <= 1'b1;
    end
  end

  // Issued-pulse position counter; clear wins over a coincident fire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_count <= '0;
    end else if (clear_pos) begin
      pos_count <= '0;
    end else if (fire) begin
      pos_count <= dir ? (pos_count + W'(1)) : (pos_count - W'(1));
    end
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen with a short tick window.
// Timing references: t0 is the cycle the tick is driven; RUN cycle j is cycle t0+21+j.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_stepper_pulse_gen;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               sync_sim_clock;
  logic signed [15:0] delta_steps;
  logic               enable;
  logic               clear_pos;
  logic               step;
  logic               dir;
  logic               busy;
  logic               overrun;
  logic signed [15:0] pos_count;

  always #5 clock = ~clock;

  stepper_pulse_gen #(
    .simPeriod(2000),
    .fixedPointBaseBits(16),
    .PULSE_WIDTH(10),
    .DIR_SETUP(20)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sync_sim_clock(sync_sim_clock),
    .delta_steps(delta_steps),
    .enable(enable),
    .clear_pos(clear_pos),
    .step(step),
    .dir(dir),
    .busy(busy),
    .overrun(overrun),
    .pos_count(pos_count)
  );

  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   sync_t = 0;
  int   rise_cnt, min_high, max_high, min_low, last_rise, last_fall;
  bit   have_fall, busy_seen;
  logic step_q;
  int   rise_q[$];

  // Advance one clock and update the pulse monitor.
  task cyc1();
    @(posedge clock);
    #1;
    cyc++;
    if (sync_sim_clock && (cyc - sync_t >= 4)) sync_sim_clock = 1'b0;
    if (step === 1'b1 && step_q !== 1'b1) begin
      rise_cnt++;
      rise_q.push_back(cyc);
      if (have_fall && (cyc - last_fall < min_low)) min_low = cyc - last_fall;
      last_rise = cyc;
    end
    if (step === 1'b0 && step_q === 1'b1) begin
      if (cyc - last_rise < min_high) min_high = cyc - last_rise;
      if (cyc - last_rise > max_high) max_high = cyc - last_rise;
      last_fall = cyc;
      have_fall = 1'b1;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    step_q = step;
  endtask

  task run_to(input int target);
    while (cyc < target) cyc1();
  endtask

  task mon_clear();
    rise_cnt  = 0;
    rise_q.delete();
    min_high  = 1000000;
    max_high  = 0;
    min_low   = 1000000;
    last_rise = 0;
    last_fall = 0;
    have_fall = 1'b0;
    busy_seen = 1'b0;
    step_q    = step;
  endtask

  task tick(input logic signed [15:0] d);
    delta_steps    = d;
    sync_sim_clock = 1'b1;
    sync_t         = cyc;
    t0             = cyc;
  endtask

  task test_reset();
    reset_n = 1'b0; enable = 1'b0; sync_sim_clock = 1'b0; delta_steps = '0; clear_pos = 1'b0;
    repeat (3) cyc1();
    tests++; if (step !== 1'b0) begin failed++; $display("FAIL reset_step: got %b want 0", step); end
    tests++; if (dir !== 1'b0) begin failed++; $display("FAIL reset_dir: got %b want 0", dir); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (pos_count !== 16'sd0) begin failed++; $display("FAIL reset_pos: got %0d want 0", pos_count); end
    reset_n = 1'b1;
    repeat (2) cyc1();
  endtask

  task test_nominal();
    enable = 1'b1;
    mon_clear();
    tick(16'sd4);
    run_to(t0 + 1);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL nom_busy_sample: got %b want 0", busy); end
    run_to(t0 + 2);
    tests++; if (dir !== 1'b1) begin failed++; $display("FAIL nom_dir: got %b want 1", dir); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL nom_busy_rise: got %b want 1", busy); end
    run_to(t0 + 269);
    tests++; if (step !== 1'b0) begin failed++; $display("FAIL nom_step_before: got %b want 0", step); end
    run_to(t0 + 270);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL nom_first_rise: got %b want 1", step); end
    tests++; if (pos_count !== 16'sd1) begin failed++; $display("FAIL nom_pos_first: got %0d want 1", pos_count); end
    run_to(t0 + 2001);
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL nom_busy_last: got %b want 1", busy); end
    run_to(t0 + 2002);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL nom_busy_fall: got %b want 0", busy); end
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 4) begin failed++; $display("FAIL nom_count: got %0d want 4", rise_cnt); end
    tests++; if (min_high !== 10 || max_high !== 10) begin failed++; $display("FAIL nom_width: got %0d..%0d want 10", min_high, max_high); end
    tests++; if (pos_count !== 16'sd4) begin failed++; $display("FAIL nom_pos: got %0d want 4", pos_count); end
    if (rise_q.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (rise_q[i] - rise_q[i-1] !== 495) begin
          failed++; $display("FAIL nom_spacing%0d: got %0d want 495", i, rise_q[i] - rise_q[i-1]);
        end
      end
    end
  endtask

  task test_zero_and_disable();
    mon_clear();
    tick(16'sd0);
    run_to(t0 + 400);
    tests++; if (rise_cnt !== 0) begin failed++; $display("FAIL zero_pulses: got %0d want 0", rise_cnt); end
    tests++; if (busy_seen !== 1'b0) begin failed++; $display("FAIL zero_busy: got %b want 0", busy_seen); end
    tests++; if (dir !== 1'b1) begin failed++; $display("FAIL zero_dir_hold: got %b want 1", dir); end
    enable = 1'b0;
    mon_clear();
    tick(16'sd5);
    run_to(t0 + 400);
    tests++; if (rise_cnt !== 0) begin failed++; $display("FAIL dis_pulses: got %0d want 0", rise_cnt); end
    tests++; if (busy_seen !== 1'b0) begin failed++; $display("FAIL dis_busy: got %b want 0", busy_seen); end
    tests++; if (pos_count !== 16'sd4) begin failed++; $display("FAIL dis_pos: got %0d want 4", pos_count); end
    enable = 1'b1;
    cyc1();
  endtask

  task test_reversal();
    int rc;
    clear_pos = 1'b1;
    cyc1();
    clear_pos = 1'b0;
    tests++; if (pos_count !== 16'sd0) begin failed++; $display("FAIL rev_clear_idle: got %0d want 0", pos_count); end
    mon_clear();
    tick(16'sd3);
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 3) begin failed++; $display("FAIL rev_fwd_count: got %0d want 3", rise_cnt); end
    tests++; if (pos_count !== 16'sd3) begin failed++; $display("FAIL rev_fwd_pos: got %0d want 3", pos_count); end
    tick(-16'sd3);
    run_to(t0 + 1);
    tests++; if (dir !== 1'b1) begin failed++; $display("FAIL rev_dir_before: got %b want 1", dir); end
    run_to(t0 + 2);
    tests++; if (dir !== 1'b0) begin failed++; $display("FAIL rev_dir_fall: got %b want 0", dir); end
    rc = rise_cnt;
    run_to(t0 + 22);
    tests++; if (rise_cnt !== rc || step !== 1'b0) begin failed++; $display("FAIL rev_setup_quiet: got %0d rises want 0", rise_cnt - rc); end
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 6) begin failed++; $display("FAIL rev_total: got %0d want 6", rise_cnt); end
    tests++; if (pos_count !== 16'sd0) begin failed++; $display("FAIL rev_pos: got %0d want 0", pos_count); end
  endtask

  task test_clamp();
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL clamp_ovr_pre: got %b want 0", overrun); end
    mon_clear();
    tick(16'sd150);
    run_to(t0 + 2);
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL clamp_ovr: got %b want 1", overrun); end
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 99) begin failed++; $display("FAIL clamp_pos_count: got %0d want 99", rise_cnt); end
    tests++; if (min_low !== 10) begin failed++; $display("FAIL clamp_min_low: got %0d want 10", min_low); end
    tests++; if (max_high !== 10) begin failed++; $display("FAIL clamp_width: got %0d want 10", max_high); end
    tests++; if (pos_count !== 16'sd99) begin failed++; $display("FAIL clamp_pos: got %0d want 99", pos_count); end
    mon_clear();
    tick(16'sh8000);
    run_to(t0 + 2);
    tests++; if (dir !== 1'b0) begin failed++; $display("FAIL clamp_neg_dir: got %b want 0", dir); end
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 99) begin failed++; $display("FAIL clamp_neg_count: got %0d want 99", rise_cnt); end
    tests++; if (pos_count !== 16'sd0) begin failed++; $display("FAIL clamp_neg_pos: got %0d want 0", pos_count); end
  endtask

  task test_enable_drop();
    mon_clear();
    tick(16'sd4);
    run_to(t0 + 273);
    enable = 1'b0;
    run_to(t0 + 274);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL endrop_busy: got %b want 0", busy); end
    run_to(t0 + 279);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL endrop_step_hold: got %b want 1", step); end
    run_to(t0 + 280);
    tests++; if (step !== 1'b0) begin failed++; $display("FAIL endrop_step_fall: got %b want 0", step); end
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 1) begin failed++; $display("FAIL endrop_count: got %0d want 1", rise_cnt); end
    tests++; if (max_high !== 10) begin failed++; $display("FAIL endrop_width: got %0d want 10", max_high); end
    tests++; if (pos_count !== 16'sd1) begin failed++; $display("FAIL endrop_pos: got %0d want 1", pos_count); end
    enable = 1'b1;
    cyc1();
  endtask

  task test_clear_and_reset();
    mon_clear();
    tick(16'sd4);
    run_to(t0 + 269);
    tests++; if (pos_count !== 16'sd1) begin failed++; $display("FAIL clr_pos_before: got %0d want 1", pos_count); end
    clear_pos = 1'b1;
    run_to(t0 + 270);
    clear_pos = 1'b0;
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL clr_step_emitted: got %b want 1", step); end
    tests++; if (pos_count !== 16'sd0) begin failed++; $display("FAIL clr_pos_wins: got %0d want 0", pos_count); end
    run_to(t0 + 765);
    tests++; if (pos_count !== 16'sd1) begin failed++; $display("FAIL clr_pos_next: got %0d want 1", pos_count); end
    run_to(t0 + 767);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL rst_step_pre: got %b want 1", step); end
    reset_n = 1'b0;
    #1;
    tests++; if (step !== 1'b0) begin failed++; $display("FAIL rst_async_step: got %b want 0", step); end
    tests++; if (dir !== 1'b0) begin failed++; $display("FAIL rst_async_dir: got %b want 0", dir); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL rst_async_overrun: got %b want 0", overrun); end
    tests++; if (pos_count !== 16'sd0) begin failed++; $display("FAIL rst_async_pos: got %0d want 0", pos_count); end
    repeat (3) cyc1();
    reset_n = 1'b1;
    cyc1();
    mon_clear();
    tick(16'sd4);
    run_to(t0 + 270);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL rst_after_rise: got %b want 1", step); end
    run_to(t0 + 2100);
    tests++; if (rise_cnt !== 4) begin failed++; $display("FAIL rst_after_count: got %0d want 4", rise_cnt); end
    tests++; if (pos_count !== 16'sd4) begin failed++; $display("FAIL rst_after_pos: got %0d want 4", pos_count); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL rst_after_overrun: got %b want 0", overrun); end
  endtask

  task test_early_tick();
    int ta;
    mon_clear();
    tick(16'sd2);
    ta = t0;
    run_to(ta + 517);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL early_inflight_rise: got %b want 1", step); end
    run_to(ta + 521);
    tick(16'sd8);
    run_to(ta + 522);
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL early_overrun: got %b want 1", overrun); end
    run_to(ta + 526);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL early_step_hold: got %b want 1", step); end
    run_to(ta + 527);
    tests++; if (step !== 1'b0) begin failed++; $display("FAIL early_step_fall: got %b want 0", step); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL early_busy_wait: got %b want 0", busy); end
    run_to(ta + 528);
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL early_busy_setup: got %b want 1", busy); end
    run_to(ta + 671);
    tests++; if (step !== 1'b0) begin failed++; $display("FAIL early_new_before: got %b want 0", step); end
    run_to(ta + 672);
    tests++; if (step !== 1'b1) begin failed++; $display("FAIL early_new_first: got %b want 1", step); end
    run_to(ta + 2700);
    tests++; if (rise_cnt !== 9) begin failed++; $display("FAIL early_count: got %0d want 9", rise_cnt); end
    tests++; if (min_high !== 10 || max_high !== 10) begin failed++; $display("FAIL early_width: got %0d..%0d want 10", min_high, max_high); end
    tests++; if (pos_count !== 16'sd13) begin failed++; $display("FAIL early_pos: got %0d want 13", pos_count); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_and_disable();
    test_reversal();
    test_clamp();
    test_enable_drop();
    test_clear_and_reset();
    test_early_tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stepper_pulse_gen.md
# stepper_pulse_gen

- Converts the per-tick `delta_steps` from `simulator` into evenly spaced STEP pulses plus a DIR level for a 1/16-microstep driver.
- Each count of `delta_steps` (step/16) is one STEP pulse. Each tick's pulses are spread across that tick's `sync_sim_clock` period.
- It sits between `simulator` and the driver pins, and keeps a running count of issued pulses for cross-checking against `current_pos`.

## Interface
- `simPeriod`, 500_000, clocks per simulation tick; must match `simulator`.
- `fixedPointBaseBits`, 16, width of `delta_steps` and `pos_count`.
- `PULSE_WIDTH`, 100, STEP high time in clocks; the minimum STEP low time is the same value.
- `DIR_SETUP`, 50, clocks from a DIR update to the earliest STEP edge.
- `clock` input 1: system clock. One clock domain.
- `reset_n` input 1: reset, asynchronous, active-low.
- `sync_sim_clock` input 1: tick clock from `simulator`. Registered in the `clock` domain.
- `delta_steps` input signed [fixedPointBaseBits-1:0]: signed pulse count for the tick.
- `enable` input 1: pulse generation enable.
- `clear_pos` input 1: synchronous clear of `pos_count`; driven from `calib_done`.
- `step` output 1: STEP pin.
- `dir` output 1: DIR pin. 1 = positive `delta_steps`.
- `busy` output 1: high while in SETUP or RUN.
- `overrun` output 1: sticky flag, set when a request was clamped or a window was aborted.
- `pos_count` output signed [fixedPointBaseBits-1:0]: signed count of issued pulses. Wraps modulo 2^fixedPointBaseBits.

## Operation
- Derived constants:
  - RUN_CYCLES = simPeriod − DIR_SETUP.
  - MAX_STEPS = RUN_CYCLES / (2·PULSE_WIDTH), integer division.
- Edge detect: `sim_prev` <= `sync_sim_clock`; rise = `sync_sim_clock` & ~`sim_prev`.
- FSM states: IDLE, SAMPLE, SETUP, RUN.
- IDLE:
  - Entered on reset.
  - On rise with `enable`=1, go to SAMPLE.
- SAMPLE (1 cycle):
  - n <= |`delta_steps`|, clamped to MAX_STEPS. Set `overrun` if the clamp applied; this includes −2^(w−1).
  - `dir` <= (`delta_steps` > 0). If `delta_steps` = 0, `dir` holds and the next state is IDLE.
  - Otherwise load the setup timer with DIR_SETUP and go to SETUP.
- SETUP:
  - Count down DIR_SETUP clocks; `step` stays low.
  - Then load acc = RUN_CYCLES/2 and the run timer = RUN_CYCLES, and go to RUN.
- RUN, each clock:
  - acc <= acc + n.
  - If acc + n ≥ RUN_CYCLES: acc <= acc + n − RUN_CYCLES and fire one pulse.
  - After RUN_CYCLES clocks, go to IDLE.
- Pulse count and spacing:
  - A window emits exactly n pulses.
  - Spacing is ≥ 2·PULSE_WIDTH, so no pulse queueing is needed.
  - The half-window initial offset ends the last pulse before the window ends.
- Fire:
  - `step` goes high on the next clock for PULSE_WIDTH clocks, timed by an independent pulse timer.
  - `pos_count` changes by ±1 according to `dir`, in the same cycle `step` rises.
- Rise outside IDLE (tick shorter than expected):
  - The window is aborted; set `overrun`; go to SAMPLE.
  - A STEP pulse in flight completes its full width.
  - The `dir` update is deferred until `step` is low.
- `enable`=0:
  - Go to IDLE at the next clock; any high pulse completes.
  - Rises are ignored while `enable`=0.
- `clear_pos`:
  - `pos_count` <= 0.
  - Wins over a simultaneous fire: the pulse is still emitted but not counted.
- `overrun` clears only on `reset_n`.
- Accumulator is unsigned, 32 bits.

## Timing
- On `reset_n` low, immediately:
  - `step`=0, `dir`=0, `busy`=0, `overrun`=0, `pos_count`=0.
  - State = IDLE; acc, n, `sim_prev` and all timers = 0.
- A reset mid-pulse drops `step` at once.
- Latency from rise detection to SAMPLE: 1 clock.
- `dir` is valid DIR_SETUP+1 clocks before the earliest possible STEP rise.
- `busy` rises on the clock after SAMPLE and falls on the clock after the final RUN cycle.
- For RUN cycle j, counting 1..RUN_CYCLES: a crossing at j gives a `step` rise at j+1 and a `step` fall at j+1+PULSE_WIDTH.

## Test plan
- Common setup: simPeriod=2000, PULSE_WIDTH=10, DIR_SETUP=20, so RUN_CYCLES=1980 and MAX_STEPS=99.
- Test 1, nominal positive: `delta_steps`=+4.
  - `dir`=1 before the first STEP.
  - Exactly 4 pulses, each 10 clocks high.
  - First STEP rise at RUN cycle 249; rises spaced 495 clocks apart.
  - `pos_count` ends at 4.
- Test 2, reversal: ticks of +3 then −3.
  - `dir` falls in SAMPLE of tick 2, with no STEP during the following 20 clocks.
  - 3 pulses, and `pos_count` returns to 0.
- Test 3, clamp: `delta_steps`=+150, then `delta_steps`=−32768.
  - +150 window: 99 pulses, minimum low time ≥ 10, `overrun`=1.
  - −32768 window: 99 pulses, `dir`=0.
- Test 4, zero and enable: `delta_steps`=0 → no pulses, `busy` stays 0, `dir` unchanged.
  - With `enable`=0 and `delta_steps`=+5 → no pulses.
  - Deassert `enable` mid-pulse → `step` completes 10 clocks, then stays low.
- Test 5, clear/reset: assert `clear_pos` in the same cycle as a fire → `pos_count`=0 and the STEP is still emitted.
  - Drop `reset_n` while `step` is high → all outputs 0 asynchronously; the next tick operates normally.
- Test 6, early tick: force a rise at RUN cycle 500 with `delta_steps`=+8.
  - `overrun`=1.
  - Any in-flight pulse keeps its full width.
  - A new window starts and emits 8 pulses.
